dff_write_arbiter: RTL and testbench
====================================

// Module: dff_write_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for one shared W-bit enable-gated D flip-flop register bank.
//  Grants write access to one of N_REQ requesters at a time and drives the bank's en/d inputs for exactly one cycle.
//  Holds the grant for HOLD_CYC settle cycles, then reads back q and compares it with the written value.
//  Signals completion to the requester. Sits between requester logic and the shared register bank.
// PARAMETERS
//  N_REQ     4  number of requesters (>=2)
//  W         8  data width of the shared register bank
//  HOLD_CYC  2  settle cycles between the write and the readback (>=1)
// PORTS
//  clk       in   1        single clock, rising edge
//  rst       in   1        asynchronous, active-low reset (0 = reset)
//  req       in   N_REQ    request per requester; level, held until done
//  wdata     in   N_REQ*W  write data; slice i = wdata[i*W +: W], stable while req[i]=1
//  gnt       out  N_REQ    one-hot grant, held from the write cycle through the HOLD cycles
//  done      out  N_REQ    one-cycle completion pulse to the granted requester
//  mismatch  out  1        one-cycle pulse with done when readback != written data
//  rdata     out  W        readback value, registered; valid while done is high
//  reg_en    out  1        enable to the shared bank; high exactly one cycle per grant
//  reg_d     out  W        data to the shared bank
//  reg_q     in   W        q of the shared bank
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; gnt, done, mismatch, reg_en = 0; reg_d, rdata = 0; ptr = 0.
//  - All outputs are registered. The shared bank is reset by its own reset, not by this block.
//  - FSM states: IDLE -> WRITE -> HOLD -> IDLE.
//  - IDLE: if |req, pick i = first set req[] searching ptr, ptr+1, .. N_REQ-1, 0, .. (wraps).
//    At the edge: gnt<=onehot(i), reg_en<=1, reg_d<=wdata[i], wr_q<=wdata[i], state<=WRITE.
//    If req=0, stay in IDLE.
//  - WRITE, one cycle: the bank captures reg_d at the closing edge.
//    At that edge: reg_en<=0, cnt<=HOLD_CYC-1, state<=HOLD.
//  - HOLD: gnt is held. cnt decrements each cycle. When cnt==0, at the edge:
//    gnt<=0, done[i]<=1, rdata<=reg_q, mismatch<=(reg_q!=wr_q),
//    ptr<=(i+1) mod N_REQ, state<=IDLE.
//  - Latency: req sampled in IDLE at cycle t; gnt/reg_en visible at t+1;
//    done visible at t+2+HOLD_CYC. done, mismatch and rdata last one cycle.
//  - The done cycle is an IDLE cycle: req is re-sampled there. A req[i] still high then is a new request.
//    Round-robin order puts it last, because ptr has moved past i.
//  - req[i] dropped mid-grant: the write and HOLD still complete and done[i] still pulses. No abort.
//  - wdata changes after the IDLE sample do not affect the write; it was captured at grant.
//  - Several req rise in the same cycle: only the round-robin winner is granted; the others wait.
//  - Fairness: with all req held high, grants are issued in order 0,1,..,N_REQ-1,0,..
//  - reset mid-grant: everything clears asynchronously; no done is issued; the bank keeps its q.
//  - Index width is $clog2(N_REQ); cnt width is $clog2(HOLD_CYC+1); ptr increment wraps modulo N_REQ.
// STRUCTURE
//  - Shared package dff_arb_pkg: state encoding (IDLE=2'd0, WRITE=2'd1, HOLD=2'd2), clog2 width constants.
//  - Sub-module rr_pick (combinational). Inputs: req, ptr. Outputs: onehot grant, index, any.
//  - Top module: FSM, hold counter, ptr register, data capture, readback compare.
//  - Verification instantiates the team's d_ff bank, W wide, with shared en, and connects reg_en, reg_d, reg_q.
// TESTING
//  1 Single requester: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 at t+1; reg_en one cycle;
//    done[2] at t+4 (HOLD_CYC=2); rdata=8'hA5; mismatch=0.
//  2 All four req high, continuously held -> grant order 0,1,2,3,0.
//    Each grant spans 1+HOLD_CYC cycles; the next grant's reg_en is 1 cycle after each done.
//  3 Simultaneous req=4'b1010 after a grant to 1 -> 3 is granted first, then 1.
//  4 Requester drops req during HOLD -> done still pulses; no re-grant.
//  5 Bank forced to hold q=8'h00 (its en tied low) while writing 8'h3C -> done with mismatch=1, rdata=8'h00.
//  6 rst low in the middle of HOLD -> gnt, reg_en, done immediately 0 (async).
//    After release, req=4'b1111 grants 0 first.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared state encoding, default sizes and width helper for the write arbiter
package dff_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, HOLD = 2'd2} state_t;
  localparam int N_REQ_D = 4;
  localparam int W_D = 8;
  localparam int HOLD_CYC_D = 2;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set req starting at ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any
);
  logic [IW:0] s;
  always_comb begin
    s = '0;
    idx = '0;
    any = 1'b0;
    // scan farthest offset first so the lowest offset from ptr wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW + 1)'(k);
      s = s >= (IW + 1)'(N_REQ) ? s - (IW + 1)'(N_REQ) : s;
      if (req[s[IW-1:0]]) begin
        idx = s[IW-1:0];
        any = 1'b1;
      end
    end
    onehot = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin write sequencer with settle and readback check for a shared register bank
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_D,
  parameter int W = W_D,
  parameter int HOLD_CYC = HOLD_CYC_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               mismatch,
  output logic [W-1:0]       rdata,
  output logic               reg_en,
  output logic [W-1:0]       reg_d,
  input  logic [W-1:0]       reg_q
);
  localparam int IW = idx_w(N_REQ);
  localparam int CW = idx_w(HOLD_CYC + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr, gi, idx;
  logic [N_REQ-1:0] onehot;
  logic any;
  logic [W-1:0] wr_q;
  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(req),
    .ptr(ptr),
    .onehot(onehot),
    .idx(idx),
    .any(any)
  );
  always_comb begin
    state_nx = state == IDLE ? (any ? WRITE : IDLE)
             : state == WRITE ? HOLD
             : (state == HOLD && cnt != '0) ? HOLD : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      gi <= '0;
      wr_q <= '0;
      gnt <= '0;
      done <= '0;
      mismatch <= 1'b0;
      rdata <= '0;
      reg_en <= 1'b0;
      reg_d <= '0;
    end else begin
      state <= state_nx;
      done <= '0;
      mismatch <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: if (any) begin
          gnt <= onehot;
          gi <= idx;
          reg_en <= 1'b1;
          reg_d <= wdata[idx*W +: W];
          wr_q <= wdata[idx*W +: W];
        end
        WRITE: begin
          reg_en <= 1'b0;
          cnt <= CW'(HOLD_CYC - 1);
        end
        HOLD: if (cnt == '0) begin
          gnt <= '0;
          done <= N_REQ'(1) << gi;
          rdata <= reg_q;
          mismatch <= reg_q != wr_q;
          ptr <= gi == IW'(N_REQ - 1) ? '0 : gi + IW'(1);
        end else begin
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb_dff_write_arbiter: directed stimulus with a queue scoreboard checked by a separate output monitor
module tb_dff_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;
  logic clk = 1'b0, rst = 1'b0, bank_rst = 1'b0, force_lo = 1'b0, end_req = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0] gnt, done;
  logic mismatch, reg_en;
  logic [W-1:0] rdata, reg_d, bank_q;
  typedef struct {logic [N-1:0] g; logic [W-1:0] d; logic b2b;} gexp_t;
  typedef struct {logic [N-1:0] dn; logic [W-1:0] r; logic mm;} dexp_t;
  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t ge;
  dexp_t de;
  int n_chk = 0, n_fail = 0, tmo = 0, since_en = 0, cyc = 0;
  logic prev_done = 1'b0, prev_en = 1'b0;
  logic [N-1:0] cur_g = '0;
  always #5 clk = ~clk;
  dff_write_arbiter #(.N_REQ(N), .W(W), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .done(done),
    .mismatch(mismatch), .rdata(rdata), .reg_en(reg_en), .reg_d(reg_d), .reg_q(bank_q)
  );
  // shared bank stand-in; force_lo ties its enable low
  always_ff @(posedge clk or negedge bank_rst) begin
    if (!bank_rst) bank_q <= '0;
    else if (reg_en && !force_lo) bank_q <= reg_d;
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic void push(int i, logic [W-1:0] d, logic b2b, logic [W-1:0] r, logic mm, bit dn);
    gq.push_back('{g: N'(1) << i, d: d, b2b: b2b});
    if (dn) dq.push_back('{dn: N'(1) << i, r: r, mm: mm});
  endfunction
  function automatic void wd(int i, logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endfunction
  task automatic wait_done(logic [N-1:0] m);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (|(done & m)) return;
    end
    tmo++;
  endtask
  task automatic wait_en();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (reg_en) return;
    end
    tmo++;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", 32'({gnt, done, mismatch, reg_en, reg_d, rdata}), 32'd0);
      since_en = 0;
      prev_done = 1'b0;
      prev_en = 1'b0;
      cur_g = '0;
    end else begin
      cyc = since_en + 1;
      if (reg_en) begin
        chk("reg_en_one_cycle", 32'(prev_en), 32'd0);
        if (gq.size() == 0) chk("spurious_grant", 32'(gnt), 32'd0);
        else begin
          ge = gq.pop_front();
          chk("gnt", 32'(gnt), 32'(ge.g));
          chk("reg_d", 32'(reg_d), 32'(ge.d));
          if (ge.b2b) chk("regrant_after_done", 32'(prev_done), 32'd1);
          cur_g = ge.g;
        end
      end else if (!(|done) && cur_g != '0) chk("gnt_hold", 32'(gnt), 32'(cur_g));
      if (|done) begin
        if (dq.size() == 0) chk("spurious_done", 32'(done), 32'd0);
        else begin
          de = dq.pop_front();
          chk("done", 32'(done), 32'(de.dn));
          chk("rdata", 32'(rdata), 32'(de.r));
          chk("mismatch", 32'(mismatch), 32'(de.mm));
          chk("done_latency", 32'(cyc), 32'(1 + H));
          chk("gnt_released", 32'(gnt), 32'd0);
        end
        cur_g = '0;
      end else chk("mismatch_idle", 32'(mismatch), 32'd0);
      since_en = reg_en ? 0 : cyc;
      prev_done = |done;
      prev_en = reg_en;
    end
    if (end_req) begin
      chk("grants_left", 32'(gq.size()), 32'd0);
      chk("dones_left", 32'(dq.size()), 32'd0);
      chk("timeouts", 32'(tmo), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bank_rst = 1'b1;
    @(negedge clk);
    // fairness: all held high from ptr=0
    wd(0, 8'h11); wd(1, 8'h22); wd(2, 8'h33); wd(3, 8'h44);
    push(0, 8'h11, 1'b0, 8'h11, 1'b0, 1);
    push(1, 8'h22, 1'b1, 8'h22, 1'b0, 1);
    push(2, 8'h33, 1'b1, 8'h33, 1'b0, 1);
    push(3, 8'h44, 1'b1, 8'h44, 1'b0, 1);
    push(0, 8'h11, 1'b1, 8'h11, 1'b0, 1);
    req = 4'hf;
    repeat (4) wait_done(4'hf);
    wait_done(4'h1);
    req = '0;
    // single requester 2, ptr=1
    @(negedge clk);
    wd(2, 8'hA5);
    push(2, 8'hA5, 1'b0, 8'hA5, 1'b0, 1);
    req = 4'b0100;
    wait_done(4'b0100);
    req = '0;
    // grant to 1, ptr becomes 2
    @(negedge clk);
    push(1, 8'h22, 1'b0, 8'h22, 1'b0, 1);
    req = 4'b0010;
    wait_done(4'b0010);
    req = '0;
    // simultaneous 1 and 3: 3 first, then 1 right after
    @(negedge clk);
    push(3, 8'h44, 1'b0, 8'h44, 1'b0, 1);
    push(1, 8'h22, 1'b1, 8'h22, 1'b0, 1);
    req = 4'b1010;
    wait_done(4'b1000);
    req = 4'b0010;
    wait_done(4'b0010);
    req = '0;
    // drop req and change wdata mid-grant
    @(negedge clk);
    wd(0, 8'h5A);
    push(0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1);
    req = 4'b0001;
    wait_en();
    @(negedge clk);
    req = '0;
    wd(0, 8'hFF);
    wait_done(4'b0001);
    repeat (5) @(negedge clk);
    // bank cleared and its enable blocked: readback mismatch
    bank_rst = 1'b0;
    @(negedge clk);
    bank_rst = 1'b1;
    force_lo = 1'b1;
    wd(2, 8'h3C);
    push(2, 8'h3C, 1'b0, 8'h00, 1'b1, 1);
    req = 4'b0100;
    wait_done(4'b0100);
    req = '0;
    @(negedge clk);
    force_lo = 1'b0;
    // reset during HOLD; ptr=3 so 3 is granted, then reset restarts at 0
    push(3, 8'h44, 1'b0, 8'h00, 1'b0, 0);
    req = 4'hf;
    wait_en();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    wd(0, 8'h77);
    push(0, 8'h77, 1'b0, 8'h77, 1'b0, 1);
    rst = 1'b1;
    wait_done(4'b0001);
    req = '0;
    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end
endmodule
